branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- 2-bit saturating-counter branch history table for the pipelined MIPS core.
- Sits around the ID-stage equality comparator. It predicts BEQ/BNE direction at IF from the PC. It carries that prediction to ID, then consumes the comparator's equal flag to resolve the branch.
- Outputs the actual direction and a mispredict pulse to the hazard/PC-select logic, and trains the table.

Parameters:
- IDX_W, 6, table index width; table holds 2^IDX_W entries, indexed by pc[IDX_W+1:2].
- INIT_CTR, 2'b01, reset value of every counter (weakly not-taken).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- if_pc  input  32  PC of the instruction currently in IF
- if_valid  input  1  IF holds a real instruction
- pred_taken  output  1  prediction for if_pc; combinational table read, bit[1] of counter
- stall  input  1  hazard unit holds IF/ID; freezes ID-side state and suppresses resolution
- flush  input  1  squash the instruction entering ID (external redirect)
- id_is_beq  input  1  decoded instruction in ID is BEQ
- id_is_bne  input  1  decoded instruction in ID is BNE
- equ  input  1  equality of forwarded rs/rt operands from the ID comparator
- actual_taken  output  1  resolved direction: beq ? equ : bne ? !equ : 0
- mispredict  output  1  combinational pulse: resolving branch whose actual_taken != carried prediction
- id_pred  output  1  prediction carried with the ID instruction (registered)

Behaviour:
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Taken means counter[1]=1.
- Training is saturating: taken → +1 capped at 11; not-taken → −1 floored at 00.
- Reset (rst=1 at an edge):
  - all counters ← INIT_CTR;
  - id_valid_q ← 0, id_pred_q ← 0, id_idx_q ← 0;
  - consequently id_pred=0, mispredict=0, actual_taken=0 the cycle after reset.
  - Reset overrides stall, flush and any pending update.
- IF→ID capture, every edge with !stall:
  - id_valid_q ← if_valid & !flush & !mispredict;
  - id_pred_q ← pred_taken;
  - id_idx_q ← if_pc[IDX_W+1:2].
  - With stall=1 all three hold.
- Resolve condition R = id_valid_q & (id_is_beq | id_is_bne) & !stall.
  - Stalled cycles never resolve, because equ may be stale while forwarding is pending.
  - A branch stalled N cycles resolves exactly once, on its first unstalled cycle.
- mispredict = R & (actual_taken != id_pred_q). It asserts in the same cycle as R, and zero cycles after equ is valid.
- actual_taken is driven whenever id_valid_q=1, and is 0 when id_valid_q=0.
- Update: on the edge ending a cycle with R=1, counter[id_idx_q] is trained with actual_taken. There is one write port and one update per cycle maximum.
- Read/write same index in the same cycle: pred_taken returns the pre-update value (no bypass). The write lands at the edge.
- mispredict=1 forces the next id_valid_q to 0, squashing the wrong-path fetch. The flush input does the same.
- Flush and mispredict together: id_valid_q ← 0; the update still happens.
- Non-branch in ID, or id_valid_q=0: no update and no mispredict, whatever equ is.
- id_is_beq and id_is_bne both high is illegal. In that case BEQ semantics apply.
- Aliasing: PCs sharing index bits share a counter. No tags.

Optional Feature:
- Macro: BRANCH_PRED_PERF_EN.
- When defined:
  - adds two 32-bit outputs, perf_branches and perf_mispredicts;
  - perf_branches increments on every R=1 cycle; perf_mispredicts increments on every mispredict=1 cycle;
  - both counters wrap at 2^32 and clear on rst.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset then repeat BEQ at pc=0x0040_0010 with equ=1, 4 times → 1st: pred 0 (INIT 01), mispredict=1, ctr→10; 2nd: pred 1, no mispredict, ctr→11; 3rd/4th: ctr stays 11.
- From ctr=11, BNE at same pc with equ=1 (not taken) → mispredict=1, actual_taken=0, ctr→10; next fetch pred_taken=1 still.
- Stall=1 for 3 cycles with a BEQ in ID and equ toggling → mispredict=0 and no counter change during stall; exactly one update on release.
- Same-index read/write: BEQ at 0x100 resolving taken while if_pc=0x100 and ctr=01 → pred_taken=0 that cycle, 1 next cycle.
- Mispredict cycle with if_valid=1 → next cycle id_valid_q=0; an ADD in ID with equ=1 gives actual_taken=0, no mispredict, no update.
- rst asserted mid-stall with a pending branch → all counters return to 01, id_pred=0, no update from the pending branch. With BRANCH_PRED_PERF_EN defined, both perf counters read 0.

Source files
------------

// File: rtl/branch_predictor_if.sv
// IF/ID-side signal bundle between the MIPS pipeline and the branch predictor.
// Perf counter outputs exist only when BRANCH_PRED_PERF_EN is defined.
interface branch_predictor_if;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        pred_taken;
  logic        stall;
  logic        flush;
  logic        id_is_beq;
  logic        id_is_bne;
  logic        equ;
  logic        actual_taken;
  logic        mispredict;
  logic        id_pred;
`ifdef BRANCH_PRED_PERF_EN
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;
`endif

  // Pipeline side: drives fetch/decode state, consumes prediction and resolution
  modport master (
    output if_pc, if_valid, stall, flush, id_is_beq, id_is_bne, equ,
`ifdef BRANCH_PRED_PERF_EN
    input  perf_branches, perf_mispredicts,
`endif
    input  pred_taken, actual_taken, mispredict, id_pred
  );

  modport slave (
    input  if_pc, if_valid, stall, flush, id_is_beq, id_is_bne, equ,
`ifdef BRANCH_PRED_PERF_EN
    output perf_branches, perf_mispredicts,
`endif
    output pred_taken, actual_taken, mispredict, id_pred
  );
endinterface

// File: rtl/branch_predictor.sv
// 2-bit saturating-counter BHT: predicts BEQ/BNE at IF, resolves in ID, trains the table.
// Optional BRANCH_PRED_PERF_EN adds wrapping branch/mispredict counters.
module branch_predictor #(
  parameter int unsigned IDX_W    = 6,
  parameter logic [1:0]  INIT_CTR = 2'b01
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);
  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [1:0]       r_ctr [DEPTH];
  logic             r_id_valid;
  logic             r_id_pred;
  logic [IDX_W-1:0] r_id_idx;

  logic [IDX_W-1:0] w_if_idx;
  logic             w_pred;
  logic             w_actual;
  logic             w_resolve;
  logic             w_mispredict;
  logic [1:0]       w_ctr_cur;
  logic [1:0]       w_ctr_next;
  logic             w_unused_pc;

  assign w_if_idx    = bp.if_pc[IDX_W+1:2];
  assign w_unused_pc = ^{bp.if_pc[31:IDX_W+2], bp.if_pc[1:0]};

  // Table read is combinational and never bypasses a same-cycle write
  assign w_pred = r_ctr[w_if_idx][1];

  // BEQ wins when both decode flags are (illegally) high
  always_comb begin
    w_actual = 1'b0;
    if (r_id_valid) begin
      if (bp.id_is_beq)      w_actual = bp.equ;
      else if (bp.id_is_bne) w_actual = ~bp.equ;
    end
  end

  // equ may be stale while stalled, so resolution waits for the first free cycle
  assign w_resolve    = r_id_valid & (bp.id_is_beq | bp.id_is_bne) & ~bp.stall;
  assign w_mispredict = w_resolve & (w_actual != r_id_pred);

  assign w_ctr_cur = r_ctr[r_id_idx];

  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (w_actual && (w_ctr_cur != 2'b11))       w_ctr_next = w_ctr_cur + 2'd1;
    else if (!w_actual && (w_ctr_cur != 2'b00)) w_ctr_next = w_ctr_cur - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_ctr[i] <= INIT_CTR;
      r_id_valid <= 1'b0;
      r_id_pred  <= 1'b0;
      r_id_idx   <= '0;
    end else begin
      if (w_resolve) r_ctr[r_id_idx] <= w_ctr_next;
      if (!bp.stall) begin
        r_id_valid <= bp.if_valid & ~bp.flush & ~w_mispredict;
        r_id_pred  <= w_pred;
        r_id_idx   <= w_if_idx;
      end
    end
  end

  assign bp.pred_taken   = w_pred;
  assign bp.actual_taken = w_actual;
  assign bp.mispredict   = w_mispredict;
  assign bp.id_pred      = r_id_pred;

`ifdef BRANCH_PRED_PERF_EN
  logic [31:0] r_perf_branches;
  logic [31:0] r_perf_mispredicts;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_branches    <= '0;
      r_perf_mispredicts <= '0;
    end else begin
      if (w_resolve)    r_perf_branches    <= r_perf_branches + 32'd1;
      if (w_mispredict) r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
    end
  end

  assign bp.perf_branches    = r_perf_branches;
  assign bp.perf_mispredicts = r_perf_mispredicts;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Randomized + directed bench for branch_predictor against a table-of-integers reference model.
// Perf counters are also checked when BRANCH_PRED_PERF_EN is defined.
module tb_branch_predictor;
  localparam int unsigned TBL = 64;

  logic clk;
  logic rst;
  branch_predictor_if bp_if ();

  branch_predictor #(.IDX_W(6), .INIT_CTR(2'b01)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_ctr [TBL];
  int m_valid, m_pred, m_idx;
  int m_br, m_mis;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < TBL; i++) m_ctr[i] = 1;
    m_valid = 0; m_pred = 0; m_idx = 0; m_br = 0; m_mis = 0;
  endtask

  // One cycle: drive, check combinational/registered outputs vs model, advance model
  task automatic step(input logic [31:0] pc, input logic v, input logic st, input logic fl,
                      input logic beq, input logic bne, input logic eq, input logic r,
                      input bit chk, output logic o_pred, output logic o_act,
                      output logic o_mis, output logic o_idp);
    int idx, e_pred, e_act, e_r, e_mis;
    @(negedge clk);
    bp_if.if_pc = pc; bp_if.if_valid = v; bp_if.stall = st; bp_if.flush = fl;
    bp_if.id_is_beq = beq; bp_if.id_is_bne = bne; bp_if.equ = eq; rst = r;
    #1;
    idx    = int'((pc >> 2) % TBL);
    e_pred = (m_ctr[idx] >= 2) ? 1 : 0;
    e_act  = (m_valid == 0) ? 0 : (beq ? int'(eq) : (bne ? int'(!eq) : 0));
    e_r    = (m_valid != 0 && (beq || bne) && !st) ? 1 : 0;
    e_mis  = (e_r != 0 && e_act != m_pred) ? 1 : 0;
    o_pred = bp_if.pred_taken; o_act = bp_if.actual_taken;
    o_mis  = bp_if.mispredict; o_idp = bp_if.id_pred;
    if (chk) begin
      check_eq("pred_taken",   32'(o_pred), 32'(e_pred));
      check_eq("actual_taken", 32'(o_act),  32'(e_act));
      check_eq("mispredict",   32'(o_mis),  32'(e_mis));
      check_eq("id_pred",      32'(o_idp),  32'(m_pred));
`ifdef BRANCH_PRED_PERF_EN
      check_eq("perf_branches",    bp_if.perf_branches,    32'(m_br));
      check_eq("perf_mispredicts", bp_if.perf_mispredicts, 32'(m_mis));
`endif
    end
    if (r) begin
      model_reset();
    end else begin
      if (e_r != 0) begin
        m_ctr[m_idx] = (e_act != 0) ? ((m_ctr[m_idx] < 3) ? m_ctr[m_idx] + 1 : 3)
                                    : ((m_ctr[m_idx] > 0) ? m_ctr[m_idx] - 1 : 0);
        m_br++;
      end
      if (e_mis != 0) m_mis++;
      if (!st) begin
        m_valid = (v && !fl && e_mis == 0) ? 1 : 0;
        m_pred  = e_pred;
        m_idx   = idx;
      end
    end
  endtask

  logic p, a, mi, ip;
  localparam logic [31:0] PC_A = 32'h0040_0010;
  localparam logic [31:0] PC_B = 32'h0000_0100;

  initial begin
    model_reset();
    step(PC_A, 0, 0, 0, 0, 0, 0, 1, 0, p, a, mi, ip);
    step(PC_A, 0, 0, 0, 0, 0, 0, 1, 1, p, a, mi, ip);
    check_eq("rst_id_pred", 32'(ip), 32'd0);

    // BEQ taken four times from weak-NT
    step(PC_A, 1, 0, 0, 0, 0, 0, 0, 1, p, a, mi, ip);
    check_eq("t1_first_pred", 32'(p), 32'd0);
    step(PC_A, 0, 0, 0, 1, 0, 1, 0, 1, p, a, mi, ip);
    check_eq("t1_first_mis", 32'(mi), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step(PC_A, 1, 0, 0, 0, 0, 0, 0, 1, p, a, mi, ip);
      check_eq("t1_pred_taken", 32'(p), 32'd1);
      step(PC_A, 0, 0, 0, 1, 0, 1, 0, 1, p, a, mi, ip);
      check_eq("t1_no_mis", 32'(mi), 32'd0);
    end

    // BNE not taken from strong-T
    step(PC_A, 1, 0, 0, 0, 0, 0, 0, 1, p, a, mi, ip);
    step(PC_A, 1, 0, 0, 0, 1, 1, 0, 1, p, a, mi, ip);
    check_eq("t2_mis", 32'(mi), 32'd1);
    check_eq("t2_act", 32'(a), 32'd0);
    step(PC_A, 1, 0, 0, 0, 0, 0, 0, 1, p, a, mi, ip);
    check_eq("t2_still_taken", 32'(p), 32'd1);

    // Branch held 3 stalled cycles with equ toggling resolves once (ctr 10 -> 01)
    for (int k = 0; k < 3; k++) begin
      step(PC_A, 0, 1, 0, 1, 0, logic'(k & 1), 0, 1, p, a, mi, ip);
      check_eq("t3_stall_no_mis", 32'(mi), 32'd0);
    end
    step(PC_A, 0, 0, 0, 1, 0, 0, 0, 1, p, a, mi, ip);
    check_eq("t3_release_mis", 32'(mi), 32'd1);
    step(PC_A, 1, 0, 0, 0, 0, 0, 0, 1, p, a, mi, ip);
    step(PC_A, 0, 0, 0, 1, 0, 1, 0, 1, p, a, mi, ip);
    step(PC_A, 1, 0, 0, 0, 0, 0, 0, 1, p, a, mi, ip);
    check_eq("t3_single_update", 32'(p), 32'd1);

    // Same-index read/write and wrong-path squash
    step(PC_B, 0, 0, 0, 0, 0, 0, 1, 1, p, a, mi, ip);
    step(PC_B, 1, 0, 0, 0, 0, 0, 0, 1, p, a, mi, ip);
    step(PC_B, 1, 0, 0, 1, 0, 1, 0, 1, p, a, mi, ip);
    check_eq("t4_pre_update_read", 32'(p), 32'd0);
    check_eq("t4_mis", 32'(mi), 32'd1);
    step(PC_B, 0, 0, 0, 1, 0, 1, 0, 1, p, a, mi, ip);
    check_eq("t4_post_update_read", 32'(p), 32'd1);
    check_eq("t5_squash_act", 32'(a), 32'd0);
    check_eq("t5_squash_mis", 32'(mi), 32'd0);

    // Reset in the middle of a stalled pending branch
    step(PC_B, 1, 0, 0, 0, 0, 0, 0, 1, p, a, mi, ip);
    step(PC_B, 0, 1, 0, 1, 0, 0, 0, 1, p, a, mi, ip);
    step(PC_B, 0, 1, 0, 1, 0, 0, 1, 1, p, a, mi, ip);
    step(PC_B, 0, 0, 0, 1, 0, 0, 0, 1, p, a, mi, ip);
    check_eq("t6_rst_pred", 32'(p), 32'd0);
    check_eq("t6_rst_id_pred", 32'(ip), 32'd0);
    check_eq("t6_rst_mis", 32'(mi), 32'd0);

    // Randomized traffic with heavy aliasing
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] rpc;
      logic rb, rn;
      rpc = 32'($urandom_range(0, 255)) << 2;
      rb  = ($urandom_range(0, 2) == 0);
      rn  = ($urandom_range(0, 2) == 0);
      step(rpc, logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) == 0),
           logic'($urandom_range(0, 9) == 0), rb, rn, logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 99) == 0), 1, p, a, mi, ip);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
